// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the inter-stage pipeline register.
//   pipe_state_t  - occupancy state of a pipe_stage_reg instance
//   PIPE_NOP_BIT  - fill bit for the nop payload (the nop is all-zero)
package pipe_pkg;

  // Occupancy of the stage: no entry, main entry only, main + skid entry.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_t;

  // The nop payload is all zero at any width; replicate this bit DATA_W times.
  localparam logic PIPE_NOP_BIT = 1'b0;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one storage entry of a pipeline stage (valid + pc + bd + payload).
//   clk, reset      - clock, synchronous active-high reset (everything to 0)
//   load            - capture d_pc/d_bd/d_data and mark the slot valid
//   clear           - drop the entry: valid=0, payload becomes the nop;
//                     pc/bd are retained when KEEP_PC=1, zeroed otherwise
//   d_pc/d_bd/d_data - entry to capture on load
//   q_valid/q_pc/q_bd/q_data - held entry
// clear wins over load when both are asserted.
module pipe_slot import pipe_pkg::*; #(
  parameter int DATA_W  = 96,
  parameter int PC_W    = 32,
  parameter bit KEEP_PC = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   d_pc,
  input  logic              d_bd,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [PC_W-1:0]   q_pc,
  output logic              q_bd,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_pc    <= '0;
      q_bd    <= 1'b0;
      q_data  <= {DATA_W{PIPE_NOP_BIT}};
    end else if (clear) begin
      q_valid <= 1'b0;
      q_data  <= {DATA_W{PIPE_NOP_BIT}};
      // Retained pc/bd lets CP0 build EPC for an instruction that was flushed.
      if (!KEEP_PC) begin
        q_pc <= '0;
        q_bd <= 1'b0;
      end
    end else if (load) begin
      q_valid <= 1'b1;
      q_pc    <= d_pc;
      q_bd    <= d_bd;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   clk, reset                 - clock, synchronous active-high reset
//   in_valid/in_ready          - upstream handshake
//   in_pc/in_bd/in_data        - upstream PC, delay-slot flag, payload
//   flush                      - kill all held entries (and any same-cycle input)
//   out_valid/out_ready        - downstream handshake
//   out_pc/out_bd/out_data     - held entry; out_data is the nop when out_valid=0
// Parameters: SKID=1 adds a second entry so in_ready comes from a flop;
// KEEP_PC=1 keeps the last PC/BD visible after the stage empties.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high (accept on the input side, drain on the output side). A source never
// waits for ready before raising valid, and ready may be high with valid low.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int DATA_W  = 96,
  parameter int PC_W    = 32,
  parameter bit SKID    = 1'b1,
  parameter bit KEEP_PC = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_bd,
  output logic [DATA_W-1:0] out_data
);

  // Current occupancy; kept as a named register so checkers can bind to it.
  pipe_state_t state;

  logic accept;
  logic drain;

  logic main_load;
  logic main_clear;
  logic skid_load;
  logic skid_clear;
  logic from_skid;

  logic [PC_W-1:0]   main_d_pc;
  logic              main_d_bd;
  logic [DATA_W-1:0] main_d_data;

  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic              skid_bd;
  logic [DATA_W-1:0] skid_data;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // With a skid entry, in_ready only looks at a flop (and reset), so the
  // downstream stall never ripples combinationally upstream.
  assign in_ready = SKID ? (~skid_valid & ~reset)
                         : ((~out_valid | out_ready) & ~reset);

  // Slot controls derived from the current state and the two handshakes.
  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    from_skid  = 1'b0;
    case (state)
      PS_EMPTY: main_load = accept;
      PS_FULL: begin
        // Without a skid entry, accept in FULL implies drain (ready follows out_ready).
        main_load  = accept & drain;
        skid_load  = accept & ~drain;
        main_clear = ~accept & drain;
      end
      PS_SKID: begin
        main_load  = drain;
        from_skid  = 1'b1;
        skid_clear = drain;
      end
      default: ;
    endcase
    // Flush turns the stage into a bubble and discards any same-cycle input.
    if (flush) begin
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  always_comb begin
    main_d_pc   = in_pc;
    main_d_bd   = in_bd;
    main_d_data = in_data;
    if (from_skid) begin
      main_d_pc   = skid_pc;
      main_d_bd   = skid_bd;
      main_d_data = skid_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PS_EMPTY;
    end else if (flush) begin
      state <= PS_EMPTY;
    end else begin
      case (state)
        PS_EMPTY: if (accept) state <= PS_FULL;
        PS_FULL: begin
          if (accept & ~drain)      state <= PS_SKID;
          else if (~accept & drain) state <= PS_EMPTY;
        end
        PS_SKID:  if (drain) state <= PS_FULL;
        default:  state <= PS_EMPTY;
      endcase
    end
  end

  pipe_slot #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .KEEP_PC (KEEP_PC)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_pc    (main_d_pc),
    .d_bd    (main_d_bd),
    .d_data  (main_d_data),
    .q_valid (out_valid),
    .q_pc    (out_pc),
    .q_bd    (out_bd),
    .q_data  (out_data)
  );

  if (SKID) begin : g_skid
    pipe_slot #(
      .DATA_W  (DATA_W),
      .PC_W    (PC_W),
      .KEEP_PC (KEEP_PC)
    ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load),
      .clear   (skid_clear),
      .d_pc    (in_pc),
      .d_bd    (in_bd),
      .d_data  (in_data),
      .q_valid (skid_valid),
      .q_pc    (skid_pc),
      .q_bd    (skid_bd),
      .q_data  (skid_data)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_pc    = '0;
    assign skid_bd    = 1'b0;
    assign skid_data  = '0;
    logic unused_skid_ctl;
    assign unused_skid_ctl = skid_load | skid_clear;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three stage instances share one input stream:
//   a: SKID=1 KEEP_PC=1, b: SKID=1 KEEP_PC=0, c: SKID=0 KEEP_PC=1.
// Each has its own expected queue, modelled as a bounded FIFO
// (capacity 2 with skid, 1 without) plus the last departed PC/BD.
module tb_pipe_stage_reg;
  localparam int DATA_W = 96;
  localparam int PC_W   = 32;
  localparam int ENT_W  = PC_W + 1 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic              in_bd;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_ready;

  logic a_in_ready, a_out_valid, a_out_bd;
  logic b_in_ready, b_out_valid, b_out_bd;
  logic c_in_ready, c_out_valid, c_out_bd;
  logic [PC_W-1:0]   a_out_pc, b_out_pc, c_out_pc;
  logic [DATA_W-1:0] a_out_data, b_out_data, c_out_data;

  pipe_stage_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .SKID(1'b1), .KEEP_PC(1'b1)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_bd(in_bd), .in_data(in_data), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_bd(a_out_bd), .out_data(a_out_data));

  pipe_stage_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .SKID(1'b1), .KEEP_PC(1'b0)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc), .in_bd(in_bd), .in_data(in_data), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_bd(b_out_bd), .out_data(b_out_data));

  pipe_stage_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .SKID(1'b0), .KEEP_PC(1'b1)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_pc(in_pc), .in_bd(in_bd), .in_data(in_data), .flush(flush),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_pc(c_out_pc),
    .out_bd(c_out_bd), .out_data(c_out_data));

  // ---------------- scoreboard state ----------------
  logic [ENT_W-1:0] exp_q0[$];
  logic [ENT_W-1:0] exp_q1[$];
  logic [ENT_W-1:0] exp_q2[$];
  logic [ENT_W-1:0] last0 = '0, last1 = '0, last2 = '0;
  logic rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;
  logic dr0 = 1'b0, dr1 = 1'b0, dr2 = 1'b0;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [ENT_W-1:0] act, input logic [ENT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string nm, input bit have, input logic [ENT_W-1:0] head,
                          input logic [ENT_W-1:0] idle, input logic rdy_exp,
                          input logic rdy, input logic valid, input logic [ENT_W-1:0] act);
    chk({nm, ".in_ready"}, rdy, rdy_exp);
    chk({nm, ".out_valid"}, valid, have);
    if (have) chk({nm, ".out_entry"}, act, head);
    else      chk({nm, ".idle_entry"}, act, idle);
  endtask

  // Monitor: on the falling edge compare each instance with the head of its
  // queue, then pop the head if the coming rising edge will consume it.
  task automatic monitor_loop();
    logic [ENT_W-1:0] h;
    forever begin
      @(negedge clk);
      rdy0 = !reset && (exp_q0.size() < 2);
      rdy1 = !reset && (exp_q1.size() < 2);
      rdy2 = !reset && (exp_q2.size() == 0 || out_ready);

      h = (exp_q0.size() > 0) ? exp_q0[0] : '0;
      cmp_inst("a", exp_q0.size() > 0, h, {last0[ENT_W-1:DATA_W], {DATA_W{1'b0}}},
               rdy0, a_in_ready, a_out_valid, {a_out_pc, a_out_bd, a_out_data});
      h = (exp_q1.size() > 0) ? exp_q1[0] : '0;
      cmp_inst("b", exp_q1.size() > 0, h, '0,
               rdy1, b_in_ready, b_out_valid, {b_out_pc, b_out_bd, b_out_data});
      h = (exp_q2.size() > 0) ? exp_q2[0] : '0;
      cmp_inst("c", exp_q2.size() > 0, h, {last2[ENT_W-1:DATA_W], {DATA_W{1'b0}}},
               rdy2, c_in_ready, c_out_valid, {c_out_pc, c_out_bd, c_out_data});

      dr0 = out_ready && (exp_q0.size() > 0);
      if (dr0) last0 = exp_q0.pop_front();
      dr1 = out_ready && (exp_q1.size() > 0);
      if (dr1) last1 = exp_q1.pop_front();
      dr2 = out_ready && (exp_q2.size() > 0);
      if (dr2) last2 = exp_q2.pop_front();
    end
  endtask

  // Stimulus side of the scoreboard: on each rising edge apply reset/flush and
  // push newly accepted entries using the ready the model predicted.
  task automatic model_loop();
    logic [ENT_W-1:0] e;
    forever begin
      @(posedge clk);
      e = {in_pc, in_bd, in_data};
      if (reset) begin
        exp_q0.delete(); last0 = '0;
        exp_q1.delete(); last1 = '0;
        exp_q2.delete(); last2 = '0;
      end else if (flush) begin
        if (!dr0 && exp_q0.size() > 0) last0 = exp_q0[0];
        if (!dr1 && exp_q1.size() > 0) last1 = exp_q1[0];
        if (!dr2 && exp_q2.size() > 0) last2 = exp_q2[0];
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
      end else begin
        if (in_valid && rdy0) exp_q0.push_back(e);
        if (in_valid && rdy1) exp_q1.push_back(e);
        if (in_valid && rdy2) exp_q2.push_back(e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic bd,
                       input logic fl, input logic ordy, input logic rst);
    in_valid  = v;
    in_pc     = pc;
    in_bd     = bd;
    in_data   = {$urandom, $urandom, $urandom};
    flush     = fl;
    out_ready = ordy;
    reset     = rst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [PC_W-1:0] pc;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    fork
      monitor_loop();
      model_loop();
    join_none

    // Reset state
    tick(); tick();
    chk("rst.in_ready", a_in_ready, 1'b0);
    chk("rst.out_valid", a_out_valid, 1'b0);
    chk("rst.out_entry", {a_out_pc, a_out_bd, a_out_data}, '0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("post_rst.in_ready", a_in_ready, 1'b1);

    // Streaming: 0x3000..0x300C back to back, latency 1
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, PC_W'(32'h3000 + 4 * i), 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("stream.a_pc", a_out_pc, PC_W'(32'h3000 + 4 * i));
      chk("stream.c_pc", c_out_pc, PC_W'(32'h3000 + 4 * i));
      chk("stream.in_ready", a_in_ready, 1'b1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Skid absorb
    drive(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h3004, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("skid.in_ready_low", a_in_ready, 1'b0);
    chk("skid.hold_pc", a_out_pc, 32'h3000);
    chk("noskid.in_ready_low", c_in_ready, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("skid.second_pc", a_out_pc, 32'h3004);
    chk("skid.in_ready_back", a_in_ready, 1'b1);
    tick();

    // Flush with retained / zeroed PC
    drive(1'b1, 32'h3010, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("flush.valid", a_out_valid, 1'b0);
    chk("flush.data", a_out_data, '0);
    chk("flush.keep_pc", a_out_pc, 32'h3010);
    chk("flush.keep_bd", a_out_bd, 1'b1);
    chk("flush.zero_pc", b_out_pc, '0);
    chk("flush.zero_bd", b_out_bd, 1'b0);

    // Flush in SKID with a simultaneous input
    drive(1'b1, 32'h3014, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h3018, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h301C, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("flush_skid.valid", a_out_valid, 1'b0);
    chk("flush_skid.in_ready", a_in_ready, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_skid.no_ghost", a_out_valid, 1'b0);
    end

    // Reset while in SKID
    drive(1'b1, 32'h3020, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h3024, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_skid.full", a_in_ready, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("rst_skid.outputs", {a_out_valid, a_out_pc, a_out_bd, a_out_data}, '0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("rst_skid.in_ready", a_in_ready, 1'b1);
    tick();

    // Pass-through ready without a skid entry
    drive(1'b1, 32'h3030, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("noskid.held", c_out_valid, 1'b1);
    chk("noskid.stall_ready", c_in_ready, 1'b0);
    drive(1'b1, 32'h3034, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("noskid.comb_ready", c_in_ready, 1'b1);
    tick();
    chk("noskid.replace_pc", c_out_pc, 32'h3034);
    chk("noskid.replace_valid", c_out_valid, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Randomized traffic with stalls, flushes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      drive($urandom_range(0, 9) < 7, pc, 1'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) == 0);
      tick();
    end

    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing the fixed-width per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It carries an opaque payload plus PC and branch-delay flag. It adds the following on top of the plain latch:
- a valid/ready handshake;
- an optional one-entry skid buffer that breaks the combinational stall path;
- a synchronous flush that inserts a bubble while optionally preserving PC/BD for CP0 EPC generation.

## Interface
Parameters:
- DATA_W, 96, payload width (e.g. instr + two operands)
- PC_W, 32, PC width
- SKID, 1, 1 = registered in_ready with skid entry; 0 = single entry, pass-through ready
- KEEP_PC, 1, 1 = flushed/drained slot retains last PC and BD; 0 = zeroed

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  PC_W  upstream PC
- in_bd  in  1  upstream instruction sits in a delay slot
- in_data  in  DATA_W  upstream payload
- flush  in  1  kill every held entry this cycle
- out_valid  out  1  out_* holds a valid instruction
- out_ready  in  1  downstream consumes this cycle
- out_pc  out  PC_W  held PC
- out_bd  out  1  held BD flag
- out_data  out  DATA_W  held payload; all-zero (nop) whenever out_valid=0

## Operation
- Handshakes:
  - accept = in_valid & in_ready
  - drain = out_valid & out_ready
- States (SKID=1):
  - EMPTY: accept -> FULL, main <= in.
  - FULL: in_ready=1.
    - accept & drain -> FULL, main <= in.
    - accept & ~drain -> SKID, skid <= in.
    - ~accept & drain -> EMPTY.
    - Otherwise hold.
  - SKID: in_ready=0.
    - drain -> FULL, main <= skid.
    - Otherwise hold.
- in_ready (SKID=1) = ~skid_valid & ~reset, taken straight from a flop.
- SKID=0:
  - Only EMPTY and FULL states exist.
  - in_ready = (~out_valid | out_ready) & ~reset.
  - accept always writes main.
- Flush:
  - Priority below reset, above all handshakes.
  - Next state is EMPTY with skid cleared and out_data zeroed.
  - A same-cycle accept is discarded; the hazard unit flushes upstream together.
- On entry to EMPTY, whether by drain without refill or by flush:
  - out_data <= 0.
  - With KEEP_PC=1, out_pc/out_bd keep the value of the departing main entry.
  - With KEEP_PC=0 they go to 0.
- FIFO order is strict; there is no reordering and no duplication.

## Timing
- Reset: out_valid=0, out_pc=0, out_bd=0, out_data=0, skid empty, state EMPTY.
- in_ready is 0 during the reset cycle and 1 the cycle after.
- Latency is 1 cycle: accept at edge N gives out_valid=1 after edge N.
- Throughput is 1 entry/cycle while out_ready=1, in both modes.
- Stall (SKID=1):
  - With out_ready=0, exactly one extra entry is absorbed.
  - in_ready drops 1 cycle after the absorb.
  - in_ready rises the cycle after the first drain from SKID.
- Reset mid-operation (any state) discards both entries within one edge.
- flush and reset together: the reset values apply.
- No output depends combinationally on out_ready when SKID=1.

## Structure
- Shared package pipe_pkg holds:
  - state encoding constants PS_EMPTY=2'd0, PS_FULL=2'd1, PS_SKID=2'd2;
  - the NOP payload constant (all zero).
- Sub-module pipe_slot (valid + pc + bd + data flop with load/clear/keep-pc controls) is instantiated twice: main, and skid when SKID=1.
- Stage decoders (ALU/MDU op selection) stay outside this block and consume out_data.

## Test plan
- Streaming: reset, then 4 back-to-back inputs PC=0x3000..0x300C with out_ready=1 -> out_pc 0x3000..0x300C on consecutive cycles, each one cycle after its accept, in_ready constant 1.
- Skid absorb: SKID=1, entry PC=0x3000 held, out_ready=0, in_valid with PC=0x3004 -> absorbed.
  - Next cycle in_ready=0 and out_pc stays 0x3000.
  - Raise out_ready -> 0x3000 then 0x3004, then in_ready=1.
- Flush with retained PC: KEEP_PC=1, held PC=0x3010, BD=1, flush=1 -> next cycle out_valid=0, out_data=0, out_pc=0x3010, out_bd=1.
  - Repeat with KEEP_PC=0 -> out_pc=0, out_bd=0.
- Flush in SKID state with a simultaneous in_valid -> state EMPTY, both entries and the input dropped, in_ready=1 next cycle, no later out_valid without new input.
- Reset while SKID (entries 0x3020/0x3024) -> all outputs 0 next cycle, in_ready=1 the cycle after.
- SKID=0, out_ready=0, out_valid=1 -> in_ready=0 in the same cycle.
  - Set out_ready=1 with in_valid=1 -> replacement accepted with no bubble.
